mu0_mem_responder: RTL and testbench

- Memory-side responder for the MU0 processor bus: the processor initiates Rd/Wr cycles and this block completes them.
- Contains a small single-port word RAM, one memory-mapped output port register and one input port.
- Adds programmable wait states and a four-phase Ready handshake, so the processor and peripherals can be exercised against slow memory.
- Sits between the MU0 core's bus pins and the testbench or top-level I/O.

---
 rtl/mu0_mem_pkg.sv | 15 +
 rtl/mu0_ram_sp.sv | 42 ++++
 rtl/mu0_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mu0_mem_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mu0_mem_pkg.sv
// Shared definitions for the MU0 memory responder: FSM encoding, port addresses
// and the wait-state counter width.
package mu0_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [11:0] PORT_OUT_ADDR = 12'hFFE;
    localparam logic [11:0] PORT_IN_ADDR  = 12'hFFF;
    localparam int          CNT_W         = 4;

endpackage

// File: rtl/mu0_ram_sp.sv
// Single-port word RAM: synchronous write, registered read updated only when re is high.
module mu0_ram_sp #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];
    logic [15:0] rdata_d;
    logic [15:0] rdata_q;

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mu0_mem_responder.sv
// MU0 bus responder: RAM plus one output and one input port, with programmable
// wait states and a four-phase Ready handshake.
module mu0_mem_responder
    import mu0_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [11:0] Addr,
    input  logic [15:0] Dout,
    output logic [15:0] Din,
    output logic        Ready,
    output logic        Err,
    output logic [15:0] PortOut,
    input  logic [15:0] PortIn
);

    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [15:0]       port_out_q, port_out_d;
    logic [15:0]       port_rd_q, port_rd_d;
    logic              ram_sel_q, ram_sel_d;

    logic              complete;
    logic [11:0]       eff_addr;
    logic [15:0]       eff_dout;
    logic              eff_rd, eff_wr, rd_only;
    logic              is_port_out, is_port_in;
    logic              ram_we, ram_re;
    logic [15:0]       ram_rdata;

    // With zero wait states the completion edge is also the sampling edge, so
    // the live bus values are used then; otherwise the latched copies.
    always_comb begin
        eff_addr    = (state_q == IDLE) ? Addr : addr_q;
        eff_dout    = (state_q == IDLE) ? Dout : dout_q;
        eff_rd      = (state_q == IDLE) ? Rd   : rd_q;
        eff_wr      = (state_q == IDLE) ? Wr   : wr_q;
        rd_only     = eff_rd & ~eff_wr;
        is_port_out = (eff_addr == PORT_OUT_ADDR);
        is_port_in  = (eff_addr == PORT_IN_ADDR);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        err_d      = err_q;
        ready_d    = ready_q;
        port_out_d = port_out_q;
        port_rd_d  = port_rd_q;
        ram_sel_d  = ram_sel_q;
        complete   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Rd | Wr) begin
                    addr_d = Addr;
                    dout_d = Dout;
                    rd_d   = Rd;
                    wr_d   = Wr;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (!Rd && !Wr) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            ready_d = 1'b1;
            err_d   = eff_rd & eff_wr;
            if (eff_wr && is_port_out) begin
                port_out_d = eff_dout;
            end
            if (rd_only) begin
                if (is_port_out) begin
                    port_rd_d = port_out_q;
                    ram_sel_d = 1'b0;
                end else if (is_port_in) begin
                    port_rd_d = PortIn;
                    ram_sel_d = 1'b0;
                end else begin
                    ram_sel_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            port_out_q <= '0;
            port_rd_q  <= '0;
            ram_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            port_out_q <= port_out_d;
            port_rd_q  <= port_rd_d;
            ram_sel_q  <= ram_sel_d;
        end
    end

    assign ram_we = complete & eff_wr  & ~is_port_out & ~is_port_in;
    assign ram_re = complete & rd_only & ~is_port_out & ~is_port_in;

    mu0_ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clk),
        .rst   (Reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (eff_addr[ADDR_W-1:0]),
        .wdata (eff_dout),
        .rdata (ram_rdata)
    );

    // Din is a mux of two registered sources, so it is stable between completions.
    assign Din     = ram_sel_q ? ram_rdata : port_rd_q;
    assign Ready   = ready_q;
    assign Err     = err_q;
    assign PortOut = port_out_q;

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Drives one bus into two responders (2 and 0 wait states) and checks both
// against a reference model through an expected-result queue.
module tb_mu0_mem_responder;

    logic        Clk;
    logic        Reset;
    logic        Rd, Wr;
    logic [11:0] Addr;
    logic [15:0] Dout;
    logic [15:0] PortIn;
    logic [15:0] din2, din0, port_out2, port_out0;
    logic        ready2, ready0, err2, err0;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];
    logic [15:0] m_ram [2][256];
    logic [15:0] port_m [2];
    logic [15:0] din_m [2];

    mu0_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Rd(Rd), .Wr(Wr), .Addr(Addr), .Dout(Dout),
        .Din(din2), .Ready(ready2), .Err(err2), .PortOut(port_out2), .PortIn(PortIn)
    );

    mu0_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Rd(Rd), .Wr(Wr), .Addr(Addr), .Dout(Dout),
        .Din(din0), .Ready(ready0), .Err(err0), .PortOut(port_out0), .PortIn(PortIn)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            port_m[i] = 16'h0000;
            din_m[i]  = 16'h0000;
        end
    endtask

    // One full four-phase transaction on both responders.
    task automatic txn(input logic rd, input logic wr, input logic [11:0] a, input logic [15:0] d);
        int n, lat2, lat0;
        logic [16:0] e2, e0;
        for (int i = 0; i < 2; i++) begin
            if (wr) begin
                if (a == 12'hFFE) port_m[i] = d;
                else if (a != 12'hFFF) m_ram[i][a[7:0]] = d;
            end else if (rd) begin
                if (a == 12'hFFE) din_m[i] = port_m[i];
                else if (a == 12'hFFF) din_m[i] = PortIn;
                else din_m[i] = m_ram[i][a[7:0]];
            end
            exp_q.push_back({rd & wr, din_m[i]});
        end
        @(negedge Clk);
        Rd = rd; Wr = wr; Addr = a; Dout = d;
        n = 0; lat2 = 0; lat0 = 0;
        while ((lat2 == 0 || lat0 == 0) && n < 40) begin
            @(posedge Clk); #1;
            n++;
            if (ready2 && lat2 == 0) lat2 = n;
            if (ready0 && lat0 == 0) lat0 = n;
            // Bus changes after sampling must be ignored.
            Addr = 12'($urandom_range(0, 4095));
            Dout = 16'($urandom_range(0, 65535));
        end
        check("latency_w2", lat2, 3);
        check("latency_w0", lat0, 1);
        e2 = exp_q.pop_front();
        e0 = exp_q.pop_front();
        check("din_w2", {16'h0, din2}, {16'h0, e2[15:0]});
        check("err_w2", {31'h0, err2}, {31'h0, e2[16]});
        check("din_w0", {16'h0, din0}, {16'h0, e0[15:0]});
        check("err_w0", {31'h0, err0}, {31'h0, e0[16]});
        @(posedge Clk); #1;
        check("ready_hold_w2", {31'h0, ready2}, 1);
        check("ready_hold_w0", {31'h0, ready0}, 1);
        check("din_hold_w2", {16'h0, din2}, {16'h0, e2[15:0]});
        @(negedge Clk);
        Rd = 1'b0; Wr = 1'b0;
        @(posedge Clk); #1;
        check("ready_fall_w2", {31'h0, ready2}, 0);
        check("err_fall_w2", {31'h0, err2}, 0);
        check("ready_fall_w0", {31'h0, ready0}, 0);
        check("portout_w2", {16'h0, port_out2}, {16'h0, port_m[0]});
        check("portout_w0", {16'h0, port_out0}, {16'h0, port_m[1]});
    endtask

    initial begin
        logic [11:0] ra;
        Reset = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; Dout = '0; PortIn = 16'h0000;
        model_reset();
        #12;
        check("rst_ready", {31'h0, ready2}, 0);
        check("rst_din", {16'h0, din2}, 0);
        check("rst_portout", {16'h0, port_out2}, 0);
        @(negedge Clk);
        Reset = 1'b0;

        txn(1'b0, 1'b1, 12'h005, 16'h80AE);
        txn(1'b1, 1'b0, 12'h005, 16'h0000);

        txn(1'b0, 1'b1, 12'h105, 16'h88AE);
        txn(1'b1, 1'b0, 12'h005, 16'h0000);
        txn(1'b0, 1'b1, 12'hFFE, 16'h1234);
        txn(1'b1, 1'b0, 12'hFFE, 16'h0000);

        txn(1'b0, 1'b1, 12'h0FF, 16'h0F0F);
        PortIn = 16'hBEEF;
        txn(1'b1, 1'b0, 12'hFFF, 16'h0000);
        txn(1'b0, 1'b1, 12'hFFF, 16'h5555);
        txn(1'b1, 1'b0, 12'h0FF, 16'h0000);

        txn(1'b1, 1'b1, 12'h010, 16'h00FF);
        txn(1'b1, 1'b0, 12'h010, 16'h0000);

        // Asynchronous reset between edges clears outputs before any edge.
        @(posedge Clk); #3;
        Reset = 1'b1;
        #1;
        check("midrst_ready", {31'h0, ready2}, 0);
        check("midrst_din", {16'h0, din2}, 0);
        check("midrst_portout", {16'h0, port_out2}, 0);
        check("midrst_portout_w0", {16'h0, port_out0}, 0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();

        txn(1'b0, 1'b1, 12'h020, 16'h1111);
        @(negedge Clk);
        Wr = 1'b1; Addr = 12'h020; Dout = 16'hAAAA;
        @(posedge Clk); #1;
        check("abort_in_wait", {31'h0, ready2}, 0);
        #2 Reset = 1'b1;
        #1;
        check("abort_ready_w2", {31'h0, ready2}, 0);
        check("abort_ready_w0", {31'h0, ready0}, 0);
        @(negedge Clk);
        Reset = 1'b0; Wr = 1'b0;
        model_reset();
        m_ram[1][8'h20] = 16'hAAAA;
        txn(1'b1, 1'b0, 12'h020, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            txn(1'b0, 1'b1, 12'h030 + 12'(i), 16'($urandom_range(0, 65535)));
        end
        for (int k = 0; k < 20; k++) begin
            ra = {4'($urandom_range(0, 15)), 8'h30 + 8'($urandom_range(0, 7))};
            PortIn = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0: txn(1'b0, 1'b1, ra, 16'($urandom_range(0, 65535)));
                1: txn(1'b1, 1'b0, ra, 16'h0000);
                2: txn(1'b0, 1'b1, 12'hFFE, 16'($urandom_range(0, 65535)));
                default: txn(1'b1, 1'b0, ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'hFFE, 16'h0000);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
